// File: rtl/rotor1_fwd_stepper.sv
// Rotor 1 forward path: position register, step-before-encode letter mapping, turnover pulse.
// Optional ring setting input is enabled by defining ROTOR_RING_SETTING_EN.
module rotor1_fwd_stepper #(
    parameter int NOTCH = 16,
    parameter int BAD   = 63
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ROTOR_RING_SETTING_EN
    input  logic [5:0] ring,
`endif
    input  logic       pos_load,
    input  logic [5:0] pos_init,
    input  logic       step_en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] data_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] data_out,
    output logic       turnover,
    output logic       err,
    output logic [5:0] position
);

    localparam logic [5:0] NOTCH_POS = NOTCH[5:0];
    localparam logic [5:0] BAD_CODE  = BAD[5:0];
    localparam logic [5:0] LAST_POS  = 6'd25;

    logic [5:0] pos_q;
    logic [5:0] data_p0;
    logic       vld_p0;
    logic       turn_p0;
    logic       err_q;

    logic       accept;
    logic       data_ok;
    logic [5:0] pos_n;
    logic [5:0] wire_idx;
    logic       ring_bad;

    function automatic logic [5:0] add_mod26(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 7'd26)
            s = s - 7'd26;
        return s[5:0];
    endfunction

    function automatic logic [5:0] wiring(input logic [5:0] idx);
        logic [5:0] w;
        case (idx)
            6'd0:    w = 6'd22;
            6'd1:    w = 6'd19;
            6'd2:    w = 6'd14;
            6'd3:    w = 6'd10;
            6'd4:    w = 6'd0;
            6'd5:    w = 6'd18;
            6'd6:    w = 6'd20;
            6'd7:    w = 6'd24;
            6'd8:    w = 6'd17;
            6'd9:    w = 6'd21;
            6'd10:   w = 6'd1;
            6'd11:   w = 6'd23;
            6'd12:   w = 6'd9;
            6'd13:   w = 6'd7;
            6'd14:   w = 6'd16;
            6'd15:   w = 6'd2;
            6'd16:   w = 6'd15;
            6'd17:   w = 6'd25;
            6'd18:   w = 6'd4;
            6'd19:   w = 6'd5;
            6'd20:   w = 6'd12;
            6'd21:   w = 6'd3;
            6'd22:   w = 6'd8;
            6'd23:   w = 6'd13;
            6'd24:   w = 6'd11;
            6'd25:   w = 6'd6;
            default: w = 6'd0;
        endcase
        return w;
    endfunction

    assign in_ready = !pos_load && (!vld_p0 || out_ready);
    assign accept   = in_valid && in_ready;
    assign data_ok  = (data_in <= LAST_POS);

    // The letter is encoded against the position the rotor moves to on this keypress.
    always_comb begin
        pos_n = pos_q;
        if (step_en)
            pos_n = (pos_q == LAST_POS) ? 6'd0 : pos_q + 6'd1;
    end

`ifdef ROTOR_RING_SETTING_EN
    logic [5:0] ring_eff;
    assign ring_bad = (ring > LAST_POS);
    assign ring_eff = ring_bad ? 6'd0 : ring;
    // Adding (26 - ring) keeps the subtraction within the 7-bit mod-26 adder.
    assign wire_idx = add_mod26(add_mod26(data_in, pos_n), 6'd26 - ring_eff);
`else
    assign ring_bad = 1'b0;
    assign wire_idx = add_mod26(data_in, pos_n);
`endif

    // Output register stage (p0): EMPTY when vld_p0=0, FULL when vld_p0=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q   <= 6'd0;
            vld_p0  <= 1'b0;
            data_p0 <= 6'd0;
            turn_p0 <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pos_load) begin
                if (pos_init <= LAST_POS)
                    pos_q <= pos_init;
                else
                    err_q <= 1'b1;
            end
            if (accept) begin
                vld_p0 <= 1'b1;
                if (data_ok) begin
                    pos_q   <= pos_n;
                    data_p0 <= wiring(wire_idx);
                    turn_p0 <= step_en && (pos_q == NOTCH_POS);
                end else begin
                    data_p0 <= BAD_CODE;
                    turn_p0 <= 1'b0;
                    err_q   <= 1'b1;
                end
                if (ring_bad)
                    err_q <= 1'b1;
            end else if (out_ready) begin
                vld_p0  <= 1'b0;
                turn_p0 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p0;
    assign data_out  = data_p0;
    assign turnover  = turn_p0;
    assign err       = err_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_rotor1_fwd_stepper.sv
// Directed-vector bench for rotor1_fwd_stepper; expected codes hand-derived from the rotor wiring.
module tb_rotor1_fwd_stepper;

    logic       clk = 1'b0;
    logic       rst;
`ifdef ROTOR_RING_SETTING_EN
    logic [5:0] ring;
`endif
    logic       pos_load;
    logic [5:0] pos_init;
    logic       step_en;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] data_in;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] data_out;
    logic       turnover;
    logic       err;
    logic [5:0] position;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rotor1_fwd_stepper dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ROTOR_RING_SETTING_EN
        .ring      (ring),
`endif
        .pos_load  (pos_load),
        .pos_init  (pos_init),
        .step_en   (step_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .turnover  (turnover),
        .err       (err),
        .position  (position)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] p);
        pos_load = 1'b1;
        pos_init = p;
        tick();
        pos_load = 1'b0;
    endtask

    task automatic send(input logic [5:0] d);
        in_valid = 1'b1;
        data_in  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pos_load = 1'b0; pos_init = 6'd0; step_en = 1'b1;
        in_valid = 1'b0; data_in = 6'd0; out_ready = 1'b1;
`ifdef ROTOR_RING_SETTING_EN
        ring = 6'd0;
`endif
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_position", position, 0);
        check("rst_turnover", turnover, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // pos_load blocks acceptance in the same cycle
        pos_load = 1'b1; pos_init = 6'd0; in_valid = 1'b1; data_in = 6'd7;
        #1;
        check("load_in_ready", in_ready, 0);
        tick();
        check("load_no_accept", out_valid, 0);
        check("load_pos0", position, 0);
        pos_load = 1'b0; in_valid = 1'b0;

        send(6'd0);
        check("a0_valid", out_valid, 1);
        check("a0_data", data_out, 19);
        check("a0_pos", position, 1);
        check("a0_turn", turnover, 0);
        check("a0_in_ready", in_ready, 1);
        tick();
        check("a0_drain", out_valid, 0);

        load(6'd25);
        send(6'd0);
        check("wrap_pos", position, 0);
        check("wrap_data", data_out, 22);
        check("wrap_turn", turnover, 0);

        // notch passage followed immediately by a back-to-back accept
        load(6'd16);
        send(6'd4);
        check("notch_pos", position, 17);
        check("notch_data", data_out, 3);
        check("notch_turn", turnover, 1);
        send(6'd0);
        check("b2b_valid", out_valid, 1);
        check("b2b_pos", position, 18);
        check("b2b_data", data_out, 4);
        check("b2b_turn", turnover, 0);
        tick();
        check("b2b_drain", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        send(6'd1);
        check("bp_data0", data_out, 12);
        in_valid = 1'b1; data_in = 6'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_data", data_out, 12);
            check("bp_in_ready", in_ready, 0);
            check("bp_pos", position, 19);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_drain", out_valid, 0);
        check("bp_pos_after", position, 19);

        send(6'd30);
        check("bad_valid", out_valid, 1);
        check("bad_data", data_out, 63);
        check("bad_err", err, 1);
        check("bad_pos", position, 19);
        check("bad_turn", turnover, 0);
        tick();
        send(6'd0);
        check("sticky_data", data_out, 12);
        check("sticky_err", err, 1);
        tick();

        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_err", err, 0);
        load(6'd5);
        load(6'd40);
        check("badinit_pos", position, 5);
        check("badinit_err", err, 1);

        step_en = 1'b0;
        send(6'd3);
        check("nostep_pos", position, 5);
        check("nostep_data", data_out, 17);
        step_en = 1'b1;
        tick();

        load(6'd25);
        send(6'd25);
        check("wrap25_pos", position, 0);
        check("wrap25_data", data_out, 6);
        tick();

        // reset while a turnover result is held by backpressure
        load(6'd16);
        out_ready = 1'b0;
        send(6'd4);
        check("hold_turn", turnover, 1);
        tick();
        check("hold_turn2", turnover, 1);
        rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_turn", turnover, 0);
        check("rstmid_data", data_out, 0);

`ifdef ROTOR_RING_SETTING_EN
        ring = 6'd1; step_en = 1'b0;
        send(6'd0);
        check("ring_data", data_out, 6);
        check("ring_err0", err, 0);
        tick();
        ring = 6'd30;
        send(6'd0);
        check("ringbad_data", data_out, 22);
        check("ringbad_err", err, 1);
        ring = 6'd0; step_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
